// File: rtl/axi_drop_packet_arb.sv
// Round-robin, packet-locked arbiter feeding one axi_drop_packet from NUM_PORTS streams.
// Define AXI_DROP_PACKET_ARB_STATS_EN to add per-port packet/truncation counters.
module axi_drop_packet_arb #(
  parameter int NUM_PORTS    = 4,
  parameter int WIDTH        = 32,
  parameter int MAX_PKT_SIZE = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic [NUM_PORTS*WIDTH-1:0]     i_tdata,
  input  logic [NUM_PORTS-1:0]           i_tvalid,
  input  logic [NUM_PORTS-1:0]           i_tlast,
  input  logic [NUM_PORTS-1:0]           i_terror,
  output logic [NUM_PORTS-1:0]           i_tready,
  output logic [WIDTH-1:0]               o_tdata,
  output logic                           o_tvalid,
  output logic                           o_tlast,
  output logic                           o_terror,
  input  logic                           o_tready,
  output logic [$clog2(NUM_PORTS)-1:0]   o_grant,
  output logic                           o_active
`ifdef AXI_DROP_PACKET_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]        stat_pkts,
  output logic [NUM_PORTS*16-1:0]        stat_trunc
`endif
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_PKT_SIZE + 1);

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  state_t          state_reg;
  logic [GW-1:0]   grant_reg;
  logic [GW-1:0]   rr_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic [WIDTH-1:0] port_data [NUM_PORTS];
  logic            g_valid;
  logic            g_last;
  logic            g_err;
  logic            in_pass;
  logic            at_max;
  logic            beat;
  logic            req_any;
  logic            found_next;
  logic [GW-1:0]   pick_next;
  int              idx_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_data[gi] = i_tdata[gi*WIDTH +: WIDTH];
      assign i_tready[gi]  = (grant_reg == GW'(gi)) &&
                             ((in_pass && o_tready) || (state_reg == DRAIN));
    end
  endgenerate

  assign g_valid = i_tvalid[grant_reg];
  assign g_last  = i_tlast[grant_reg];
  assign g_err   = i_terror[grant_reg];
  assign in_pass = (state_reg == PASS);
  // at_max marks the beat that would be word MAX_PKT_SIZE of the packet
  assign at_max  = (count_reg == CW'(MAX_PKT_SIZE - 1));
  assign beat    = in_pass && g_valid && o_tready;
  assign req_any = |i_tvalid;

  assign o_tdata  = port_data[grant_reg];
  assign o_tvalid = in_pass && g_valid;
  assign o_tlast  = o_tvalid && (g_last || at_max);
  assign o_terror = o_tvalid && (g_last ? g_err : at_max);
  assign o_grant  = grant_reg;
  assign o_active = (state_reg != IDLE);

  // Search starts just after the last served port so it ends up lowest priority
  always_comb begin
    pick_next  = rr_ptr_reg;
    found_next = 1'b0;
    idx_next   = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx_next = int'(rr_ptr_reg) + k;
      if (idx_next >= NUM_PORTS) idx_next = idx_next - NUM_PORTS;
      if (!found_next && i_tvalid[GW'(idx_next)]) begin
        found_next = 1'b1;
        pick_next  = GW'(idx_next);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= GW'(NUM_PORTS - 1);
      count_reg  <= '0;
    end else if (clear) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= GW'(NUM_PORTS - 1);
      count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            grant_reg  <= pick_next;
            rr_ptr_reg <= pick_next;
            state_reg  <= PASS;
          end
        end
        PASS: begin
          if (beat) begin
            if (g_last) begin
              count_reg <= '0;
              state_reg <= IDLE;
            end else if (at_max) begin
              count_reg <= '0;
              state_reg <= DRAIN;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (g_valid && g_last) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef AXI_DROP_PACKET_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
      logic [15:0] pkts_reg;
      logic [15:0] trunc_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pkts_reg  <= '0;
          trunc_reg <= '0;
        end else if (clear) begin
          pkts_reg  <= '0;
          trunc_reg <= '0;
        end else if (beat && (grant_reg == GW'(gi))) begin
          if (g_last) begin
            if (pkts_reg != 16'hFFFF) pkts_reg <= pkts_reg + 16'd1;
          end else if (at_max) begin
            if (trunc_reg != 16'hFFFF) trunc_reg <= trunc_reg + 16'd1;
          end
        end
      end
      assign stat_pkts[gi*16 +: 16]  = pkts_reg;
      assign stat_trunc[gi*16 +: 16] = trunc_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_axi_drop_packet_arb.sv
// Randomized bench for axi_drop_packet_arb against a packet-level reference model.
module tb_axi_drop_packet_arb;

  localparam int NP   = 4;
  localparam int W    = 32;
  localparam int MAXP = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clear;
  logic [NP*W-1:0]   i_tdata;
  logic [NP-1:0]     i_tvalid;
  logic [NP-1:0]     i_tlast;
  logic [NP-1:0]     i_terror;
  logic [NP-1:0]     i_tready;
  logic [W-1:0]      o_tdata;
  logic              o_tvalid;
  logic              o_tlast;
  logic              o_terror;
  logic              o_tready;
  logic [1:0]        o_grant;
  logic              o_active;
`ifdef AXI_DROP_PACKET_ARB_STATS_EN
  logic [NP*16-1:0]  stat_pkts;
  logic [NP*16-1:0]  stat_trunc;
`endif

  always #5 clk = ~clk;

  axi_drop_packet_arb #(.NUM_PORTS(NP), .WIDTH(W), .MAX_PKT_SIZE(MAXP)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_terror(i_terror),
    .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_terror(o_terror),
    .o_tready(o_tready), .o_grant(o_grant), .o_active(o_active)
`ifdef AXI_DROP_PACKET_ARB_STATS_EN
    , .stat_pkts(stat_pkts), .stat_trunc(stat_trunc)
`endif
  );

  typedef struct packed { logic [31:0] d; logic l; logic e; } word_t;
  typedef struct { int port; int words; bit err; } pkt_t;

  word_t src_q [NP][$];
  int    seq_cnt [NP];
  int    vprob [NP];
  int    rprob;
  pkt_t  pkt_log [$];

  int checks   = 0;
  int failures = 0;

  // Reference model: which port owns the output and how far into its packet we are
  bit m_busy, m_drain;
  int m_port, m_rr, m_grant, m_cnt;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_pkt(input int p, input int len, input bit err);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.d = {4'(p), 28'(seq_cnt[p])};
      seq_cnt[p]++;
      w.l = (i == len - 1);
      w.e = w.l & err;
      src_q[p].push_back(w);
    end
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0 && int'($urandom_range(99)) < vprob[p]) begin
        i_tvalid[p]        = 1'b1;
        i_tdata[p*W +: W]  = src_q[p][0].d;
        i_tlast[p]         = src_q[p][0].l;
        i_terror[p]        = src_q[p][0].e;
      end else begin
        i_tvalid[p]        = 1'b0;
        i_tdata[p*W +: W]  = $urandom;
        i_tlast[p]         = 1'($urandom);
        i_terror[p]        = 1'($urandom);
      end
    end
    o_tready = (int'($urandom_range(99)) < rprob);
  endtask

  task automatic model_step();
    logic [NP-1:0] exp_rdy;
    word_t w;
    bit trunc;
    int idx;
    exp_rdy = '0;
    check_value("grant", 64'(o_grant), 64'(m_grant));
    check_value("active", 64'(o_active), 64'(m_busy));
    if (!m_busy) begin
      check_value("idle_tvalid", 64'(o_tvalid), 64'd0);
      check_value("idle_tready", 64'(i_tready), 64'd0);
      if (|i_tvalid) begin
        for (int k = NP; k >= 1; k--) begin
          idx = (m_rr + k) % NP;
          if (i_tvalid[idx]) m_port = idx;
        end
        m_grant = m_port; m_rr = m_port;
        m_busy = 1'b1; m_drain = 1'b0; m_cnt = 0;
      end
    end else if (!m_drain) begin
      exp_rdy[m_port] = o_tready;
      check_value("pass_tvalid", 64'(o_tvalid), 64'(i_tvalid[m_port]));
      check_value("pass_tready", 64'(i_tready), 64'(exp_rdy));
      if (i_tvalid[m_port]) begin
        w = src_q[m_port][0];
        trunc = !w.l && (m_cnt == MAXP - 1);
        check_value("tdata", 64'(o_tdata), 64'(w.d));
        check_value("tlast", 64'(o_tlast), 64'(w.l | trunc));
        check_value("terror", 64'(o_terror), 64'(w.l ? w.e : trunc));
        if (o_tready) begin
          void'(src_q[m_port].pop_front());
          m_cnt++;
          if (w.l || trunc) begin
            pkt_log.push_back('{m_port, m_cnt, w.l ? w.e : 1'b1});
            $display("pkt port=%0d words=%0d err=%0d", m_port, m_cnt, w.l ? w.e : 1'b1);
            if (w.l) m_busy = 1'b0;
            else     m_drain = 1'b1;
          end
        end
      end else begin
        check_value("tlast_no_valid", 64'(o_tlast), 64'd0);
      end
    end else begin
      exp_rdy[m_port] = 1'b1;
      check_value("drain_tvalid", 64'(o_tvalid), 64'd0);
      check_value("drain_tready", 64'(i_tready), 64'(exp_rdy));
      if (i_tvalid[m_port]) begin
        w = src_q[m_port].pop_front();
        if (w.l) m_busy = 1'b0;
      end
    end
  endtask

  task automatic run(input int max_cycles, input bit until_done);
    int n = 0;
    bit done;
    while (1) begin
      done = all_empty() && !m_busy;
      if (until_done && done) break;
      if (n >= max_cycles) begin
        if (until_done) check_value("drain_timeout", 64'(done), 64'd1);
        break;
      end
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      model_step();
      n++;
    end
  endtask

  task automatic check_log(input string tag, input int i, input int port, input int words, input bit err);
    if (pkt_log.size() > i) begin
      check_value({tag, "_port"}, 64'(pkt_log[i].port), 64'(port));
      check_value({tag, "_words"}, 64'(pkt_log[i].words), 64'(words));
      check_value({tag, "_err"}, 64'(pkt_log[i].err), 64'(err));
    end else begin
      check_value({tag, "_missing"}, 64'(pkt_log.size()), 64'(i + 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0;
    i_tdata = '0; i_tvalid = '0; i_tlast = '0; i_terror = '0; o_tready = 1'b1;
    for (int p = 0; p < NP; p++) begin vprob[p] = 100; seq_cnt[p] = 0; end
    rprob = 100;
    m_busy = 1'b0; m_drain = 1'b0; m_rr = NP - 1; m_grant = 0; m_port = 0; m_cnt = 0;

    // Reset: outputs quiet, grant zero, even with requests pending
    i_tvalid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_tvalid", 64'(o_tvalid), 64'd0);
    check_value("rst_tready", 64'(i_tready), 64'd0);
    check_value("rst_grant", 64'(o_grant), 64'd0);
    check_value("rst_active", 64'(o_active), 64'd0);
    @(posedge clk); #1;
    i_tvalid = '0;
    reset_n = 1'b1;
    run(5, 1'b0);

    // Round robin order from reset pointer
    for (int p = 0; p < NP; p++) add_pkt(p, 8, 1'b0);
    pkt_log.delete();
    run(2000, 1'b1);
    for (int p = 0; p < NP; p++) check_log("rr", p, p, 8, 1'b0);

    // Packet lock with a gappy source
    pkt_log.delete();
    add_pkt(1, 16, 1'b0);
    run(2, 1'b0);
    vprob[1] = 50;
    add_pkt(0, 4, 1'b0);
    run(2000, 1'b1);
    check_log("lock0", 0, 1, 16, 1'b0);
    check_log("lock1", 1, 0, 4, 1'b0);
    vprob[1] = 100;

    // Error passthrough
    pkt_log.delete();
    add_pkt(2, 4, 1'b1);
    run(2000, 1'b1);
    check_log("err", 0, 2, 4, 1'b1);

    // Oversize truncation then a normal packet
    pkt_log.delete();
    add_pkt(3, 70, 1'b0);
    add_pkt(3, 5, 1'b0);
    run(2000, 1'b1);
    check_log("trunc", 0, 3, 64, 1'b1);
    check_log("after_trunc", 1, 3, 5, 1'b0);
`ifdef AXI_DROP_PACKET_ARB_STATS_EN
    check_value("stat_trunc3", 64'(stat_trunc[3*16 +: 16]), 64'd1);
    check_value("stat_pkts3", 64'(stat_pkts[3*16 +: 16]), 64'd2);
`endif

    // Exactly MAX_PKT_SIZE words is not truncated
    pkt_log.delete();
    add_pkt(0, 64, 1'b0);
    run(2000, 1'b1);
    check_log("max_len", 0, 0, 64, 1'b0);

    // Clear mid-packet abandons it and restores the rr pointer
    add_pkt(2, 20, 1'b0);
    run(6, 1'b0);
    @(posedge clk); #1;
    clear = 1'b1; i_tvalid = '0; o_tready = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    m_busy = 1'b0; m_drain = 1'b0; m_rr = NP - 1; m_grant = 0; m_cnt = 0;
    @(negedge clk);
    check_value("clr_active", 64'(o_active), 64'd0);
    check_value("clr_grant", 64'(o_grant), 64'd0);
    check_value("clr_tvalid", 64'(o_tvalid), 64'd0);
    pkt_log.delete();
    add_pkt(1, 3, 1'b0);
    add_pkt(3, 3, 1'b0);
    run(2000, 1'b1);
    check_log("clr_first", 0, 1, 3, 1'b0);
    check_log("clr_second", 1, 3, 3, 1'b0);

    // Random traffic with valid and ready gaps
    for (int p = 0; p < NP; p++) vprob[p] = 75;
    rprob = 70;
    for (int i = 0; i < 500; i++) begin
      int p, len;
      p = int'($urandom_range(NP - 1));
      if ($urandom_range(19) == 0) len = 65 + int'($urandom_range(15));
      else                         len = 1 + int'($urandom_range(MAXP - 1));
      add_pkt(p, len, 1'($urandom));
    end
    run(90000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
